rr_mux_arb: RTL and testbench
=============================

RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, number of input channels (2..16).
REQ-002 The block SHALL have parameter WIDTH, default 8, data width per channel (1..64).
REQ-003 The block SHALL have parameter RR_MODE, default 1; 1 = round-robin arbitration, 0 = fixed priority with channel 0 highest.
REQ-004 Port list SHALL be: clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  N_CH  per-channel request.
REQ-007 in_data  in  N_CH*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 in_ready  out  N_CH  one-hot or zero; channel k data taken this cycle when in_valid[k] and in_ready[k].
REQ-009 out_valid  out  1  output register holds a word.
REQ-010 out_data  out  WIDTH  registered selected word.
REQ-011 out_ch  out  clog2(N_CH)  index of the channel that supplied out_data.
REQ-012 out_ready  in  1  downstream accepts out_data this cycle when out_valid and out_ready.

Function
REQ-013 The block SHALL compute load = !out_valid || out_ready (combinational); no grant when load is 0.
REQ-014 When load is 1 and any in_valid bit is set, exactly one in_ready bit SHALL be 1, for the winning channel; otherwise in_ready SHALL be all zero.
REQ-015 in_ready SHALL NOT depend combinationally on out_data or out_ch; only in_valid, out_valid, out_ready and state.
REQ-016 RR_MODE=1: winner SHALL be the first requesting channel searching upward from pointer ptr, wrapping from N_CH-1 to 0.
REQ-017 RR_MODE=1: on a grant to channel g, ptr SHALL become g+1, wrapping to 0 when g = N_CH-1; with no grant ptr holds.
REQ-018 RR_MODE=0: winner SHALL be the lowest-indexed requesting channel; ptr stays 0.
REQ-019 On a grant, out_data, out_ch and out_valid=1 SHALL update on the next clock edge (latency 1 cycle).
REQ-020 When load is 1 and no channel requests, out_valid SHALL clear on the next edge; out_data and out_ch hold.
REQ-021 When out_valid=1 and out_ready=0, out_valid, out_data and out_ch SHALL hold, and in_ready SHALL be all zero.
REQ-022 Simultaneous drain and grant (out_valid=1, out_ready=1, request present) SHALL replace the word with no bubble, sustaining one word per cycle.
REQ-023 A channel requesting continuously SHALL be granted at least once every N_CH grants in RR_MODE=1.
REQ-024 No word SHALL be duplicated or dropped; each handshake on input side maps to exactly one output handshake, in grant order.

Reset
REQ-025 While rst_n=0: out_valid=0, out_data=0, out_ch=0, ptr=0, in_ready all zero, regardless of clk.
REQ-026 Reset asserted mid-transfer SHALL discard the held word; first grant after release SHALL start searching from channel 0.

Structure
REQ-027 Package rr_mux_pkg SHALL hold the clog2-based index-width function and the RR_MODE encoding constants.
REQ-028 One sub-module, rr_prio_pick (rotating priority encoder: request vector + start index -> one-hot grant + index), SHALL be used; the remainder is datapath and output register in rr_mux_arb.

Verification
REQ-029 Reset: rst_n=0 with all in_valid=1 -> out_valid=0, in_ready=0000, out_data=0x00.
REQ-030 RR fairness: N_CH=4, in_valid=1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 with one word per cycle.
REQ-031 Backpressure: out_valid=1, out_data=0xA5, out_ready=0 for 3 cycles -> out_data holds 0xA5, in_ready=0000; out_ready=1 -> next word loaded same edge.
REQ-032 Wrap and skip: ptr=3, in_valid=0101 -> grant channel 0, then channel 2, ptr then 3.
REQ-033 Fixed priority: RR_MODE=0, in_valid=0110 held -> out_ch stays 1 every cycle; channel 2 starved.
REQ-034 Mid-operation reset: rst_n pulsed low between clock edges while out_valid=1 -> out_valid=0 immediately; after release, in_valid=1000 -> out_ch=3 one cycle later.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin arbitrating multiplexer.
// Holds the arbitration-mode encoding and the channel-index width function.
package rr_mux_pkg;

  localparam int RR_MODE_FIXED       = 0;
  localparam int RR_MODE_ROUND_ROBIN = 1;

  // Index width never drops below one bit so a 2-channel build still has a port.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating priority encoder: finds the first set request at or above start_i,
// wrapping past the top channel, and reports it as one-hot plus binary index.
module rr_prio_pick
  import rr_mux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // The first hit wins; later hits are masked by any_o.
  always_comb begin : pickLogic
    int          cand;
    logic [IW-1:0] candIdx;
    gnt_o   = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    candIdx = '0;
    for (int i = 0; i < N; i++) begin
      cand = int'(start_i) + i;
      if (cand >= N) begin
        cand = cand - N;
      end
      candIdx = IW'(cand);
      if (!any_o && req_i[candIdx]) begin
        gnt_o[candIdx] = 1'b1;
        idx_o          = candIdx;
        any_o          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel valid/ready multiplexer with round-robin or fixed-priority
// arbitration feeding a single registered output stage.
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int WIDTH   = 8,
  parameter  int RR_MODE = RR_MODE_ROUND_ROBIN,
  localparam int IW      = idx_width(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [IW-1:0]         out_ch,
  input  logic                  out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [IW-1:0]    out_ch_q,    out_ch_d;
  logic [IW-1:0]    ptr_q,       ptr_d;

  logic             load;
  logic             grant;
  logic [IW-1:0]    searchStart;
  logic [N_CH-1:0]  gntOneHot;
  logic [IW-1:0]    gntIdx;
  logic             gntAny;
  logic [WIDTH-1:0] chWord [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_split
    assign chWord[k] = in_data[k*WIDTH +: WIDTH];
  end

  // The output register can take a word when it is empty or being drained now.
  assign load        = !out_valid_q || out_ready;
  assign searchStart = (RR_MODE == RR_MODE_ROUND_ROBIN) ? ptr_q : '0;

  rr_prio_pick #(
    .N (N_CH)
  ) u_pick (
    .req_i   (in_valid),
    .start_i (searchStart),
    .gnt_o   (gntOneHot),
    .idx_o   (gntIdx),
    .any_o   (gntAny)
  );

  // Reset gating keeps in_ready quiet while the asynchronous reset is held.
  assign grant    = rst_n && load && gntAny;
  assign in_ready = grant ? gntOneHot : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = chWord[gntIdx];
      out_ch_d    = gntIdx;
      if (RR_MODE == RR_MODE_ROUND_ROBIN) begin
        ptr_d = (gntIdx == IW'(N_CH - 1)) ? '0 : gntIdx + IW'(1);
      end
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Self-checking bench: a round-robin and a fixed-priority instance share the
// same stimulus and are each compared every cycle against a queue-free model.
`timescale 1ns/100ps
module tb_rr_mux_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  inValid = 4'b1111;
  logic [7:0]  chanData [4];
  logic [31:0] inData;
  logic        outReady = 1'b1;

  logic [3:0]  dutReady [2];
  logic        dutValid [2];
  logic [7:0]  dutData  [2];
  logic [1:0]  dutCh    [2];

  int total = 0;
  int bad   = 0;

  // Index 0 models the round-robin DUT, index 1 the fixed-priority DUT.
  logic        mValid [2] = '{1'b0, 1'b0};
  logic [7:0]  mData  [2] = '{8'h00, 8'h00};
  int          mCh    [2] = '{0, 0};
  int          mPtr   [2] = '{0, 0};

  assign inData = {chanData[3], chanData[2], chanData[1], chanData[0]};

  always #5 clk = ~clk;

  rr_mux_arb #(.N_CH(4), .WIDTH(8), .RR_MODE(1)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid),
    .in_data   (inData),
    .in_ready  (dutReady[0]),
    .out_valid (dutValid[0]),
    .out_data  (dutData[0]),
    .out_ch    (dutCh[0]),
    .out_ready (outReady)
  );

  rr_mux_arb #(.N_CH(4), .WIDTH(8), .RR_MODE(0)) u_fx (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid),
    .in_data   (inData),
    .in_ready  (dutReady[1]),
    .out_valid (dutValid[1]),
    .out_data  (dutData[1]),
    .out_ch    (dutCh[1]),
    .out_ready (outReady)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner under the arbitration rules, or -1 when nothing may be granted.
  function automatic int expectedWinner(input int m);
    int start;
    if (!rst_n) return -1;
    if (mValid[m] && !outReady) return -1;
    start = (m == 0) ? mPtr[0] : 0;
    for (int i = 0; i < 4; i++) begin
      if (inValid[(start + i) % 4]) return (start + i) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        mValid[m] = 1'b0;
        mData[m]  = 8'h00;
        mCh[m]    = 0;
        mPtr[m]   = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        int w;
        w = expectedWinner(m);
        if (w >= 0) begin
          mValid[m] = 1'b1;
          mData[m]  = chanData[w];
          mCh[m]    = w;
          if (m == 0) mPtr[m] = (w + 1) % 4;
        end else if (!mValid[m] || outReady) begin
          mValid[m] = 1'b0;
        end
      end
    end
  end

  // Outputs are compared mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int w;
      logic [3:0] expReady;
      w = expectedWinner(m);
      expReady = (w >= 0) ? 4'(1 << w) : 4'b0000;
      checkOutput(m == 0 ? "rr.in_ready"  : "fx.in_ready",  32'(dutReady[m]), 32'(expReady));
      checkOutput(m == 0 ? "rr.out_valid" : "fx.out_valid", 32'(dutValid[m]), 32'(mValid[m]));
      checkOutput(m == 0 ? "rr.out_data"  : "fx.out_data",  32'(dutData[m]),  32'(mData[m]));
      checkOutput(m == 0 ? "rr.out_ch"    : "fx.out_ch",    32'(dutCh[m]),    32'(mCh[m]));
    end
  end

  task automatic applyStimulus(input logic [3:0] v, input logic r);
    inValid  = v;
    outReady = r;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int expSeq [6];
    expSeq = '{0, 1, 2, 3, 0, 1};
    for (int k = 0; k < 4; k++) chanData[k] = 8'h10 + 8'(k);

    // Reset held with every channel requesting.
    #3;
    checkOutput("reset out_valid", 32'(dutValid[0]), 32'h0);
    checkOutput("reset in_ready",  32'(dutReady[0]), 32'h0);
    checkOutput("reset out_data",  32'(dutData[0]),  32'h00);
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    #1;
    checkOutput("first in_ready", 32'(dutReady[0]), 32'b0001);
    #1;

    // Round-robin rotation, one word per cycle.
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checkOutput("rr seq out_ch",    32'(dutCh[0]),    32'(expSeq[i]));
      checkOutput("rr seq out_valid", 32'(dutValid[0]), 32'h1);
      checkOutput("rr seq out_data",  32'(dutData[0]),  32'h10 + 32'(expSeq[i]));
      checkOutput("fx seq out_ch",    32'(dutCh[1]),    32'h0);
    end

    // Backpressure on a held 0xA5 word.
    chanData[2] = 8'hA5;
    applyStimulus(4'b0100, 1'b1);
    stepCycle();
    checkOutput("bp load out_data", 32'(dutData[0]), 32'hA5);
    applyStimulus(4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("bp in_ready",  32'(dutReady[0]), 32'h0);
      checkOutput("bp out_data",  32'(dutData[0]),  32'hA5);
      checkOutput("bp out_valid", 32'(dutValid[0]), 32'h1);
      checkOutput("bp out_ch",    32'(dutCh[0]),    32'h2);
      #1;
      stepCycle();
    end
    applyStimulus(4'b1111, 1'b1);
    #1;
    checkOutput("bp release in_ready", 32'(dutReady[0]), 32'b1000);
    #1;
    stepCycle();
    checkOutput("bp release out_ch",   32'(dutCh[0]),   32'h3);
    checkOutput("bp release out_data", 32'(dutData[0]), 32'h13);

    // Pointer to 3, then wrap to 0 and skip to 2.
    applyStimulus(4'b0100, 1'b1);
    stepCycle();
    applyStimulus(4'b0101, 1'b1);
    #1;
    checkOutput("wrap in_ready", 32'(dutReady[0]), 32'b0001);
    #1;
    stepCycle();
    checkOutput("wrap out_ch", 32'(dutCh[0]), 32'h0);
    checkOutput("skip in_ready", 32'(dutReady[0]), 32'b0100);
    stepCycle();
    checkOutput("skip out_ch", 32'(dutCh[0]), 32'h2);

    // Idle cycle drains the register but keeps data and channel.
    applyStimulus(4'b0000, 1'b1);
    stepCycle();
    checkOutput("idle out_valid", 32'(dutValid[0]), 32'h0);
    checkOutput("idle out_ch",    32'(dutCh[0]),    32'h2);
    checkOutput("idle out_data",  32'(dutData[0]),  32'hA5);
    applyStimulus(4'b1111, 1'b1);
    #1;
    checkOutput("ptr after skip", 32'(dutReady[0]), 32'b1000);
    #1;

    // Fixed priority starves channel 2.
    applyStimulus(4'b0110, 1'b1);
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("fx starve out_ch",    32'(dutCh[1]),    32'h1);
      checkOutput("fx starve out_valid", 32'(dutValid[1]), 32'h1);
    end

    // Reset pulsed between edges while a word is held.
    applyStimulus(4'b1000, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst rr out_valid", 32'(dutValid[0]), 32'h0);
    checkOutput("midrst fx out_valid", 32'(dutValid[1]), 32'h0);
    checkOutput("midrst in_ready",     32'(dutReady[0]), 32'h0);
    checkOutput("midrst out_data",     32'(dutData[0]),  32'h0);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("post rst out_ch",    32'(dutCh[0]),    32'h3);
    checkOutput("post rst out_valid", 32'(dutValid[0]), 32'h1);
    applyStimulus(4'b1010, 1'b1);
    stepCycle();
    checkOutput("post rst ptr wrap", 32'(dutCh[0]), 32'h1);

    // Mixed traffic under random backpressure, checked by the model.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 4; k++) chanData[k] = 8'($urandom);
      applyStimulus(4'($urandom), ($urandom_range(0, 3) != 0));
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
